// File: rtl/sound_pkg.sv
// Shared definitions for the sound players: FSM state encoding and standard pacing dividers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sound_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PUSH    = 3'd3,
        ST_WAIT    = 3'd4
    } state_t;

    // CLOCK_50 cycles per sample period for the two common playback rates
    localparam int RATE_DIV_8K  = 6250;
    localparam int RATE_DIV_16K = 3125;

    // Audio_Controller channel word width
    localparam int CHAN_W = 32;

endpackage

// File: rtl/sample_pacer.sv
// Sample-period pacer: free-running 0..RATE_DIV-1 counter with a tick on the last count.
// Latency: tick is combinational from the counter; clear takes effect on the next edge.
// Backpressure: none; the counter runs while en=1 and sits at 0 otherwise.
module sample_pacer #(
    parameter int RATE_DIV = 6250,
    parameter int CNT_W    = 13
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count while enabled, wrap on the last count; clear or disable parks it at 0
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sound_sample_player.sv
// Streams a clip of PCM samples from song RAM to the Audio_Controller, one sample per period.
// Latency: play to first write_audio_out is 3 cycles (FETCH, CAPTURE, PUSH) when allowed is high.
// Backpressure: waits in PUSH for audio_out_allowed; if the period expires first the sample is dropped and underrun is set.
// Optional feature: define SOUND_VOLUME_EN to add vol_shift (arithmetic attenuation applied at capture).
module sound_sample_player
    import sound_pkg::*;
#(
    parameter int SAMPLE_W = 14,
    parameter int ADDR_W   = 16,
    parameter int RATE_DIV = RATE_DIV_8K,
    parameter int CNT_W    = 13
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                play,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [SAMPLE_W-1:0] ram_q,
    input  logic                audio_out_allowed,
`ifdef SOUND_VOLUME_EN
    input  logic [1:0]          vol_shift,
`endif
    output logic                write_audio_out,
    output logic [CHAN_W-1:0]   left_audio_out,
    output logic [CHAN_W-1:0]   right_audio_out,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    localparam int JUSTIFY = CHAN_W - SAMPLE_W;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   start_q;
    logic [ADDR_W-1:0]   end_q;
    logic                loop_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic [CHAN_W-1:0]   out_q;
    logic                done_q;
    logic                underrun_q;
    logic [SAMPLE_W-1:0] captured;
    logic [CHAN_W-1:0]   word;
    logic                push_fire;
    logic                tick;

`ifdef SOUND_VOLUME_EN
    logic [1:0] vol_q;
    assign captured = SAMPLE_W'($signed(ram_q) >>> vol_q);
`else
    assign captured = ram_q;
`endif

    // Sample left-justified into the channel word, low bits zero
    assign word = CHAN_W'(sample_q) << JUSTIFY;

    // A write happens only in the cycle the controller has room; an abort in the same cycle suppresses it
    assign push_fire = (state == ST_PUSH) && audio_out_allowed && !stop && !play;

    assign write_audio_out = push_fire;
    assign left_audio_out  = push_fire ? word : out_q;
    assign right_audio_out = left_audio_out;
    assign ram_addr        = addr_q;
    assign busy            = (state != ST_IDLE);
    assign done            = done_q;
    assign underrun        = underrun_q;

    sample_pacer #(
        .RATE_DIV (RATE_DIV),
        .CNT_W    (CNT_W)
    ) u_pacer (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .clear    (play || stop),
        .en       (busy),
        .tick     (tick)
    );

    // Playback FSM: stop beats play beats period tick; the tick advances the address from PUSH or WAIT
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            start_q    <= '0;
            end_q      <= '0;
            loop_q     <= 1'b0;
            sample_q   <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef SOUND_VOLUME_EN
            vol_q      <= 2'd0;
`endif
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state  <= ST_IDLE;
                addr_q <= '0;
                out_q  <= '0;
            end else if (play) begin
                state      <= ST_FETCH;
                addr_q     <= start_addr;
                start_q    <= start_addr;
                end_q      <= end_addr;
                loop_q     <= loop_en;
                underrun_q <= 1'b0;
`ifdef SOUND_VOLUME_EN
                vol_q      <= vol_shift;
`endif
            end else begin
                case (state)
                    ST_FETCH: begin
                        state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        sample_q <= captured;
                        state    <= ST_PUSH;
                    end
                    ST_PUSH, ST_WAIT: begin
                        if (push_fire) begin
                            out_q <= word;
                        end
                        if (tick) begin
                            if ((state == ST_PUSH) && !push_fire) begin
                                underrun_q <= 1'b1;
                            end
                            if (addr_q == end_q) begin
                                if (loop_q) begin
                                    addr_q <= start_q;
                                    state  <= ST_FETCH;
                                end else begin
                                    addr_q <= '0;
                                    out_q  <= '0;
                                    done_q <= 1'b1;
                                    state  <= ST_IDLE;
                                end
                            end else begin
                                addr_q <= addr_q + ADDR_W'(1);
                                state  <= ST_FETCH;
                            end
                        end else if (push_fire) begin
                            state <= ST_WAIT;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
